// File: rtl/bpsk_pkg.sv
// Shared constants, FSM state type and sine table generator for the BPSK demodulator.
package bpsk_pkg;

  localparam int unsigned DATA_WIDTH      = 12;
  localparam int unsigned SINE_RESOLUTION = 256;
  localparam int unsigned WAVELENGTH      = 64;
  localparam int unsigned PACKET_SIZE     = 184;
  localparam int unsigned SINE_WIDTH      = 12;
  localparam int unsigned SYNC_WIDTH      = 16;
  localparam logic [SYNC_WIDTH-1:0] SYNC_WORD = 16'hF35A;

  localparam int unsigned IDX_WIDTH  = $clog2(WAVELENGTH);
  localparam int unsigned LUT_AW     = $clog2(SINE_RESOLUTION);
  localparam int unsigned LUT_SHIFT  = LUT_AW - IDX_WIDTH;
  localparam int unsigned PROD_WIDTH = DATA_WIDTH + 1 + SINE_WIDTH;
  localparam int unsigned ACC_WIDTH  = DATA_WIDTH + 1 + SINE_WIDTH + IDX_WIDTH;
  localparam int unsigned CNT_WIDTH  = $clog2(PACKET_SIZE);

  typedef enum logic {
    SEARCH,
    LOCKED
  } demod_state_t;

  // Integer sine approximation (Bhaskara), full scale +/-(2**(SINE_WIDTH-1)-1).
  // Only ever evaluated on constants, so it folds to a ROM.
  function automatic logic signed [SINE_WIDTH-1:0] sine_entry(input int idx);
    int half;
    int p;
    int a;
    int amp;
    int mag;
    half = int'(SINE_RESOLUTION / 2);
    p    = idx % half;
    a    = p * (half - p);
    amp  = (2 ** (int'(SINE_WIDTH) - 1)) - 1;
    mag  = (amp * 16 * a) / (5 * half * half - 4 * a);
    return SINE_WIDTH'((idx >= half) ? -mag : mag);
  endfunction

endpackage

// File: rtl/bpsk_demodulator_sine_lut.sv
// Signed sine lookup table shared with the modulator; purely combinational read.
module sine_lut
  import bpsk_pkg::*;
(
  input  logic        [LUT_AW-1:0]     addr,
  output logic signed [SINE_WIDTH-1:0] value
);

  logic signed [SINE_WIDTH-1:0] rom [SINE_RESOLUTION];

  for (genvar g = 0; g < SINE_RESOLUTION; g++) begin : g_rom
    assign rom[g] = sine_entry(g);
  end

  // Table read
  always_comb begin
    value = rom[addr];
  end

endmodule

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK demodulator: correlates each WAVELENGTH-sample window against the
// sine table, hunts for the sync word, then emits PACKET_SIZE payload bits.
// Optional macro BPSK_DEMOD_POLARITY_EN: also lock on the complemented sync word
// and complement the payload (180-degree carrier ambiguity).
module bpsk_demodulator
  import bpsk_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_en,
  input  logic                  sync_clear,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  packet_done,
  output logic                  locked
);

  logic        [IDX_WIDTH-1:0]  sample_idx;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [DATA_WIDTH:0]   s;
  logic signed [SINE_WIDTH-1:0] ref_val;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic        [LUT_AW-1:0]     lut_addr;
  logic                         wrap;
  logic                         decide;
  logic                         raw_bit;

  demod_state_t                 state, state_next;
  logic [SYNC_WIDTH-1:0]        history, history_next, hist_shift;
  logic [CNT_WIDTH-1:0]         bit_cnt, bit_cnt_next;
  logic                         bit_out_next, bit_valid_next, packet_done_next;
  logic                         invert;
`ifdef BPSK_DEMOD_POLARITY_EN
  logic                         invert_next;
`else
  assign invert = 1'b0;
`endif

  sine_lut u_sine_lut (
    .addr  (lut_addr),
    .value (ref_val)
  );

  // Correlator arithmetic for the sample currently presented
  always_comb begin
    s        = $signed({1'b0, sample_in}) - $signed({2'b01, {(DATA_WIDTH-1){1'b0}}});
    lut_addr = LUT_AW'(sample_idx) << LUT_SHIFT;
    prod     = s * ref_val;
    acc_sum  = acc + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    wrap     = (sample_idx == IDX_WIDTH'(WAVELENGTH - 1));
    decide   = sample_en && wrap && !sync_clear;
    raw_bit  = ~acc_sum[ACC_WIDTH-1];
    hist_shift = {history[SYNC_WIDTH-2:0], raw_bit};
  end

  // MAC and sample phase counter; the accumulator restarts on the wrapping sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      sample_idx <= '0;
    end else if (sync_clear) begin
      acc        <= '0;
      sample_idx <= '0;
    end else if (sample_en) begin
      sample_idx <= sample_idx + IDX_WIDTH'(1);
      acc        <= wrap ? '0 : acc_sum;
    end
  end

  // FSM state, sync history and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      history     <= '0;
      bit_cnt     <= '0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      packet_done <= 1'b0;
`ifdef BPSK_DEMOD_POLARITY_EN
      invert      <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      history     <= history_next;
      bit_cnt     <= bit_cnt_next;
      bit_out     <= bit_out_next;
      bit_valid   <= bit_valid_next;
      packet_done <= packet_done_next;
`ifdef BPSK_DEMOD_POLARITY_EN
      invert      <= invert_next;
`endif
    end
  end

  // Next-state and output decode; sync_clear overrides a same-cycle decision
  always_comb begin
    state_next       = state;
    history_next     = history;
    bit_cnt_next     = bit_cnt;
    bit_out_next     = 1'b0;
    bit_valid_next   = 1'b0;
    packet_done_next = 1'b0;
`ifdef BPSK_DEMOD_POLARITY_EN
    invert_next      = invert;
`endif
    if (sync_clear) begin
      state_next   = SEARCH;
      history_next = '0;
      bit_cnt_next = '0;
`ifdef BPSK_DEMOD_POLARITY_EN
      invert_next  = 1'b0;
`endif
    end else if (decide) begin
      case (state)
        SEARCH: begin
          history_next = hist_shift;
          if (hist_shift == SYNC_WORD) begin
            state_next   = LOCKED;
            bit_cnt_next = '0;
`ifdef BPSK_DEMOD_POLARITY_EN
            invert_next  = 1'b0;
          end else if (hist_shift == ~SYNC_WORD) begin
            state_next   = LOCKED;
            bit_cnt_next = '0;
            invert_next  = 1'b1;
`endif
          end
        end
        LOCKED: begin
          bit_out_next   = raw_bit ^ invert;
          bit_valid_next = 1'b1;
          bit_cnt_next   = bit_cnt + CNT_WIDTH'(1);
          if (bit_cnt == CNT_WIDTH'(PACKET_SIZE - 1)) begin
            packet_done_next = 1'b1;
            state_next       = SEARCH;
            history_next     = '0;
            bit_cnt_next     = '0;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Directed bench for bpsk_demodulator with a behavioural BPSK modulator and a
// scoreboard of expected payload bits consumed by an output monitor.
module tb_bpsk_demodulator;

  localparam int WL   = 64;
  localparam int PKT  = 184;
  localparam logic [15:0] SW = 16'hF35A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] sample_in;
  logic        sample_en;
  logic        sync_clear;
  logic        bit_out;
  logic        bit_valid;
  logic        packet_done;
  logic        locked;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_cyc = -1;
  int   exp_gap = 0;
  int   strobe_count = 0;

  bpsk_demodulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_in   (sample_in),
    .sample_en   (sample_en),
    .sync_clear  (sync_clear),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .packet_done (packet_done),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bit_valid === 1'b1) begin
      exp_t e;
      strobe_count++;
      chk("strobe_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("bit_out", bit_out, e.b);
        chk("packet_done", packet_done, e.last);
      end
      if (exp_gap != 0 && last_cyc >= 0) chk("strobe_gap", cyc - last_cyc, exp_gap);
      last_cyc = cyc;
    end
  end

  function automatic logic [11:0] mod_sample(input bit b, input int i);
    real v;
    int  k;
    v = 1000.0 * $sin(2.0 * 3.14159265358979 * i / WL);
    k = int'(v);
    return b ? 12'(2048 + k) : 12'(2048 - k);
  endfunction

  task automatic send_bit(input bit b, input int gap);
    for (int i = 0; i < WL; i++) begin
      sample_in = mod_sample(b, i);
      sample_en = 1'b1;
      @(posedge clk); #1;
      if (gap > 1) begin
        sample_en = 1'b0;
        sample_in = 12'($urandom);
        repeat (gap - 1) @(posedge clk);
        #1;
      end
    end
  endtask

  // Sync word then nbits of alternating 1,0 payload, optionally complemented on air
  task automatic send_frame(input logic [15:0] sw, input bit flip, input int gap,
                            input int nbits, input bit expect_lock, input string tag);
    bit pb;
    last_cyc = -1;
    exp_gap  = WL * gap;
    for (int k = 15; k >= 0; k--) begin
      send_bit(sw[k], gap);
      if (k == 1) chk({tag, "_locked_pre"}, locked, 0);
    end
    chk({tag, "_locked_post"}, locked, expect_lock);
    for (int j = 0; j < nbits; j++) begin
      pb = (j % 2 == 0);
      if (expect_lock) sb.push_back('{b: pb, last: (j == PKT - 1)});
      send_bit(pb ^ flip, gap);
    end
  endtask

  initial begin
    int sc0;
    rst_n      = 1'b0;
    sample_in  = '0;
    sample_en  = 1'b0;
    sync_clear = 1'b0;

    // 1: reset with toggling inputs
    #1;
    for (int i = 0; i < 6; i++) begin
      sample_en = 1'($urandom);
      sample_in = 12'($urandom);
      @(posedge clk); #1;
      chk("rst_outputs", {bit_out, bit_valid, packet_done, locked}, 4'b0000);
    end
    sample_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2: clean frame
    sc0 = strobe_count;
    send_frame(SW, 1'b0, 1, PKT, 1'b1, "clean");
    repeat (3) @(posedge clk); #1;
    chk("clean_drained", sb.size(), 0);
    chk("clean_strobes", strobe_count - sc0, PKT);
    chk("clean_unlock", locked, 0);

    // 3: inverted carrier
    sc0 = strobe_count;
`ifdef BPSK_DEMOD_POLARITY_EN
    send_frame(~SW, 1'b1, 1, PKT, 1'b1, "inv");
    repeat (3) @(posedge clk); #1;
    chk("inv_strobes", strobe_count - sc0, PKT);
`else
    send_frame(~SW, 1'b1, 1, 30, 1'b0, "inv");
    chk("inv_strobes", strobe_count - sc0, 0);
`endif
    chk("inv_drained", sb.size(), 0);
    chk("inv_unlock", locked, 0);

    // 4: sample_en gated 1-of-3
    sc0 = strobe_count;
    send_frame(SW, 1'b0, 3, PKT, 1'b1, "gated");
    repeat (3) @(posedge clk); #1;
    chk("gated_drained", sb.size(), 0);
    chk("gated_strobes", strobe_count - sc0, PKT);
    chk("gated_unlock", locked, 0);

    // 5: sync_clear after 50 payload bits, then a full resend
    send_frame(SW, 1'b0, 1, 50, 1'b1, "clr");
    sync_clear = 1'b1;
    sample_en  = 1'b1;
    sample_in  = 12'($urandom);
    @(posedge clk); #1;
    sync_clear = 1'b0;
    sample_en  = 1'b0;
    chk("clr_unlock", locked, 0);
    repeat (3) @(posedge clk); #1;
    sc0 = strobe_count;
    chk("clr_drained", sb.size(), 0);
    send_frame(SW, 1'b0, 1, PKT, 1'b1, "resend");
    repeat (3) @(posedge clk); #1;
    chk("resend_drained", sb.size(), 0);
    chk("resend_strobes", strobe_count - sc0, PKT);

    // 6: reset mid-packet, then constant midscale never locks
    send_frame(SW, 1'b0, 1, 100, 1'b1, "midrst");
    @(negedge clk); #1;
    chk("midrst_drained", sb.size(), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_async", {bit_out, bit_valid, packet_done, locked}, 4'b0000);
    sample_en = 1'b1;
    repeat (4) begin
      sample_in = 12'($urandom);
      @(posedge clk); #1;
    end
    chk("midrst_held", {bit_out, bit_valid, packet_done, locked}, 4'b0000);
    sample_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sc0 = strobe_count;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < WL; i++) begin
        sample_in = 12'd2048;
        sample_en = 1'b1;
        @(posedge clk); #1;
      end
      chk("midscale_nolock", locked, 0);
    end
    sample_en = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("midscale_strobes", strobe_count - sc0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
